// File: rtl/register_tree_pkg.sv
// rtl/register_tree_pkg.sv - shared FSM state type and heap index helpers for register_tree
package register_tree_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SORT = 1'b1
    } state_t;

    function automatic int node_count(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int parent_idx(input int i);
        return (i - 1) / 2;
    endfunction

    function automatic int left_child(input int i);
        return 2 * i + 1;
    endfunction

    function automatic int right_child(input int i);
        return 2 * i + 2;
    endfunction

    // Level of a breadth-first node index: floor(log2(i+1)).
    function automatic int level_of(input int i);
        int lvl;
        lvl = 0;
        for (int b = 0; b < 31; b++) begin
            if (((i + 1) >> b) != 0) begin
                lvl = b;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/register_tree_comparator.sv
// rtl/register_tree_comparator.sv - parent/children compare-and-swap datapath for one internal node
module comparator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_parent,
    input  logic [DATA_WIDTH-1:0] i_left,
    input  logic [DATA_WIDTH-1:0] i_right,
    output logic [DATA_WIDTH-1:0] o_parent,
    output logic [DATA_WIDTH-1:0] o_left,
    output logic [DATA_WIDTH-1:0] o_right
);

    // Promote the larger child when it strictly beats the parent; equal children favour the right one.
    always_comb begin
        o_parent = i_parent;
        o_left   = i_left;
        o_right  = i_right;
        if ((i_right >= i_left) && (i_right > i_parent)) begin
            o_parent = i_right;
            o_right  = i_parent;
        end else if ((i_left > i_right) && (i_left > i_parent)) begin
            o_parent = i_left;
            o_left   = i_parent;
        end
    end

endmodule

// File: rtl/register_tree.sv
// rtl/register_tree.sv - register-based max-heap priority queue; optional REGISTER_TREE_ERR_EN adds sticky overflow/underflow flags
module register_tree
    import register_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TREE_DEPTH = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enqueue,
    input  logic                            i_dequeue,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_ready,
    output logic                            o_empty,
    output logic                            o_full,
`ifdef REGISTER_TREE_ERR_EN
    output logic                            o_overflow,
    output logic                            o_underflow,
`endif
    output logic [$clog2(2**TREE_DEPTH)-1:0] o_size
);

    localparam int N  = node_count(TREE_DEPTH);
    localparam int NI = N / 2;
    localparam int SW = $clog2(N + 1);
    localparam int PW = $clog2(2 * TREE_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * TREE_DEPTH - 1);
    localparam logic [SW-1:0] FULL_SIZE  = SW'(N);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_node [N];
    logic [DATA_WIDTH-1:0] w_node_next [N];
    logic [SW-1:0]         r_size;
    logic [PW-1:0]         r_phase;

    logic                  w_idle;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_do_enq;
    logic                  w_do_deq;
    logic                  w_do_rep;
    logic                  w_accept;
    logic [SW-1:0]         w_last;

    logic [DATA_WIDTH-1:0] w_cmp_par [NI];
    logic [DATA_WIDTH-1:0] w_cmp_lft [NI];
    logic [DATA_WIDTH-1:0] w_cmp_rgt [NI];
    logic                  w_lvl_odd [NI];

    assign w_idle   = (r_state == IDLE);
    assign w_empty  = (r_size == '0);
    assign w_full   = (r_size == FULL_SIZE);
    assign w_last   = r_size - SW'(1);
    // A simultaneous request on an empty heap degenerates to a plain insert.
    assign w_do_enq = w_idle && i_enqueue && (!i_dequeue || w_empty) && !w_full;
    assign w_do_deq = w_idle && i_dequeue && !i_enqueue && !w_empty;
    assign w_do_rep = w_idle && i_enqueue && i_dequeue && !w_empty;
    assign w_accept = w_do_enq || w_do_deq || w_do_rep;

    assign o_data  = r_node[0];
    assign o_ready = w_idle;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_size  = r_size;

    genvar p;
    generate
        for (p = 0; p < NI; p++) begin : g_cmp
            localparam int LVL = level_of(p);
            assign w_lvl_odd[p] = LVL[0];
            comparator #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_cmp (
                .i_parent (r_node[p]),
                .i_left   (r_node[left_child(p)]),
                .i_right  (r_node[right_child(p)]),
                .o_parent (w_cmp_par[p]),
                .o_left   (w_cmp_lft[p]),
                .o_right  (w_cmp_rgt[p])
            );
        end
    endgenerate

    // Odd-even level network: only comparators on levels matching the phase parity write back,
    // so no two active comparators ever share a node.
    always_comb begin
        w_node_next = r_node;
        for (int k = 0; k < NI; k++) begin
            if (w_lvl_odd[k] == r_phase[0]) begin
                w_node_next[k]         = w_cmp_par[k];
                w_node_next[2 * k + 1] = w_cmp_lft[k];
                w_node_next[2 * k + 2] = w_cmp_rgt[k];
            end
        end
    end

    // Next-state: leave IDLE on an accepted operation, return after the last sort phase.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = SORT;
            SORT: if (r_phase == LAST_PHASE) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Node storage, occupancy and phase counter: edits happen on accept, reordering during SORT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N; k++) begin
                r_node[k] <= '0;
            end
            r_size  <= '0;
            r_phase <= '0;
        end else if (r_state == SORT) begin
            r_node  <= w_node_next;
            r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
        end else begin
            r_phase <= '0;
            if (w_do_rep) begin
                r_node[0] <= i_data;
            end else if (w_do_enq) begin
                r_node[r_size] <= i_data;
                r_size         <= r_size + SW'(1);
            end else if (w_do_deq) begin
                // Last occupied key moves to the root; its slot is cleared to keep unused nodes at 0.
                r_node[0]      <= r_node[w_last];
                r_node[w_last] <= '0;
                r_size         <= w_last;
            end
        end
    end

`ifdef REGISTER_TREE_ERR_EN
    logic r_overflow;
    logic r_underflow;

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    // Sticky flags for requests dropped in IDLE because the heap was full or empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_idle) begin
            if (i_enqueue && !i_dequeue && w_full) begin
                r_overflow <= 1'b1;
            end
            if (i_dequeue && !i_enqueue && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_tree.sv
// tb/tb_register_tree.sv - directed self-checking bench for register_tree
module tb_register_tree;

    localparam int DW    = 32;
    localparam int DEPTH = 3;
    localparam int SORT_CYCLES = 2 * DEPTH;

    logic              clk;
    logic              rst;
    logic              enq;
    logic              deq;
    logic [DW-1:0]     din;
    logic [DW-1:0]     dout;
    logic              ready;
    logic              empty;
    logic              full;
    logic [DEPTH-1:0]  size;
`ifdef REGISTER_TREE_ERR_EN
    logic              ovf;
    logic              unf;
`endif

    int n_cmp;
    int n_err;

    register_tree #(
        .DATA_WIDTH (DW),
        .TREE_DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enqueue   (enq),
        .i_dequeue   (deq),
        .i_data      (din),
        .o_data      (dout),
        .o_ready     (ready),
        .o_empty     (empty),
        .o_full      (full),
`ifdef REGISTER_TREE_ERR_EN
        .o_overflow  (ovf),
        .o_underflow (unf),
`endif
        .o_size      (size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!ready && cyc < 50) begin
            step();
            cyc++;
        end
        if (!ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_ready: o_ready=%0b after %0d cycles, required 1", ready, cyc);
        end
    endtask

    task automatic op(input logic e, input logic d, input logic [DW-1:0] v);
        wait_ready();
        enq = e;
        deq = d;
        din = v;
        step();
        enq = 1'b0;
        deq = 1'b0;
        din = '0;
        wait_ready();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        din = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dout !== 32'd0)  begin n_err++; $display("FAIL reset_data: got %0d want 0", dout); end
        n_cmp++; if (ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %0b want 1", ready); end
        n_cmp++; if (empty !== 1'b1)  begin n_err++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0)   begin n_err++; $display("FAIL reset_full: got %0b want 0", full); end
        n_cmp++; if (size !== 3'd0)   begin n_err++; $display("FAIL reset_size: got %0d want 0", size); end
    endtask

    task automatic test_enqueue();
        op(1'b1, 1'b0, 32'd5);
        op(1'b1, 1'b0, 32'd9);
        op(1'b1, 1'b0, 32'd3);
        op(1'b1, 1'b0, 32'd7);
        n_cmp++; if (dout !== 32'd9) begin n_err++; $display("FAIL enq_data: got %0d want 9", dout); end
        n_cmp++; if (size !== 3'd4)  begin n_err++; $display("FAIL enq_size: got %0d want 4", size); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL enq_empty: got %0b want 0", empty); end
    endtask

    task automatic test_dequeue();
        logic [DW-1:0] exp_seq [4];
        exp_seq[0] = 32'd9;
        exp_seq[1] = 32'd7;
        exp_seq[2] = 32'd5;
        exp_seq[3] = 32'd3;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            n_cmp++;
            if (dout !== exp_seq[i]) begin
                n_err++;
                $display("FAIL deq_root_%0d: got %0d want %0d", i, dout, exp_seq[i]);
            end
            op(1'b0, 1'b1, 32'd0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL deq_empty: got %0b want 1", empty); end
        n_cmp++; if (dout !== 32'd0) begin n_err++; $display("FAIL deq_data: got %0d want 0", dout); end
        n_cmp++; if (size !== 3'd0)  begin n_err++; $display("FAIL deq_size: got %0d want 0", size); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            op(1'b1, 1'b0, DW'(i));
        end
        n_cmp++; if (full !== 1'b1)  begin n_err++; $display("FAIL full_flag: got %0b want 1", full); end
        n_cmp++; if (dout !== 32'd7) begin n_err++; $display("FAIL full_data: got %0d want 7", dout); end
        enq = 1'b1;
        din = 32'd100;
        step();
        enq = 1'b0;
        din = '0;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL full_ign_ready: got %0b want 1", ready); end
        n_cmp++; if (dout !== 32'd7) begin n_err++; $display("FAIL full_ign_data: got %0d want 7", dout); end
        n_cmp++; if (size !== 3'd7)  begin n_err++; $display("FAIL full_ign_size: got %0d want 7", size); end
`ifdef REGISTER_TREE_ERR_EN
        n_cmp++; if (ovf !== 1'b1)   begin n_err++; $display("FAIL overflow: got %0b want 1", ovf); end
`endif
    endtask

    task automatic test_replace();
        do_reset();
        op(1'b1, 1'b0, 32'd8);
        op(1'b1, 1'b0, 32'd4);
        op(1'b1, 1'b0, 32'd2);
        op(1'b1, 1'b1, 32'd6);
        n_cmp++; if (size !== 3'd3)  begin n_err++; $display("FAIL rep_size: got %0d want 3", size); end
        n_cmp++; if (dout !== 32'd6) begin n_err++; $display("FAIL rep_data: got %0d want 6", dout); end
        op(1'b0, 1'b1, 32'd0);
        n_cmp++; if (dout !== 32'd4) begin n_err++; $display("FAIL rep_next_root: got %0d want 4", dout); end
        n_cmp++; if (size !== 3'd2)  begin n_err++; $display("FAIL rep_next_size: got %0d want 2", size); end
    endtask

    task automatic test_reset_mid_sort();
        do_reset();
        wait_ready();
        enq = 1'b1;
        din = 32'd9;
        step();
        enq = 1'b0;
        din = '0;
        step();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL midsort_busy: got %0b want 0", ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midsort_ready: got %0b want 1", ready); end
        n_cmp++; if (size !== 3'd0)  begin n_err++; $display("FAIL midsort_size: got %0d want 0", size); end
        n_cmp++; if (dout !== 32'd0) begin n_err++; $display("FAIL midsort_data: got %0d want 0", dout); end
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        do_reset();
        deq = 1'b1;
        step();
        deq = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_deq_empty_ready: got %0b want 1", ready); end
`ifdef REGISTER_TREE_ERR_EN
        n_cmp++; if (unf !== 1'b1)   begin n_err++; $display("FAIL underflow: got %0b want 1", unf); end
`endif
        low_cnt = 0;
        enq = 1'b1;
        din = 32'd50;
        for (int i = 0; i <= SORT_CYCLES; i++) begin
            step();
            if (!ready) low_cnt++;
        end
        enq = 1'b0;
        din = '0;
        n_cmp++; if (low_cnt != SORT_CYCLES) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want %0d", low_cnt, SORT_CYCLES); end
        n_cmp++; if (ready !== 1'b1)  begin n_err++; $display("FAIL b2b_ready: got %0b want 1", ready); end
        n_cmp++; if (size !== 3'd1)   begin n_err++; $display("FAIL b2b_size: got %0d want 1", size); end
        n_cmp++; if (dout !== 32'd50) begin n_err++; $display("FAIL b2b_data: got %0d want 50", dout); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        din = '0;
        test_reset();
        test_enqueue();
        test_dequeue();
        test_full();
        test_replace();
        test_reset_mid_sort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_tree.md
REGISTER_TREE -- requirements
Module: register_tree

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the unsigned key width.
REQ-002 The module SHALL have parameter TREE_DEPTH, default 3, giving the number of levels; node count N = 2^TREE_DEPTH - 1.
REQ-003 Port i_clk SHALL be an input of width 1; it is the single clock, and all state is rising-edge.
REQ-004 Port i_rst SHALL be an input of width 1; it is the synchronous, active-high reset.
REQ-005 Port i_enqueue SHALL be an input of width 1; it is the insert request.
REQ-006 Port i_dequeue SHALL be an input of width 1; it is the remove-max request.
REQ-007 Port i_data SHALL be an input of width DATA_WIDTH; it is the key to insert.
REQ-008 Port o_data SHALL be an output of width DATA_WIDTH; it is the root (current maximum).
REQ-009 Port o_ready SHALL be an output of width 1; high means an operation may be accepted.
REQ-010 Port o_empty SHALL be an output of width 1; high when size = 0.
REQ-011 Port o_full SHALL be an output of width 1; high when size = N.
REQ-012 Port o_size SHALL be an output of width $clog2(N+1); it is the occupied node count.

Function
REQ-013 Nodes SHALL be stored breadth-first as node[0..N-1], with the children of i at 2i+1 and 2i+2; occupied nodes are always exactly indices 0..size-1, and unoccupied nodes hold 0.
REQ-014 The FSM SHALL have two states, IDLE and SORT; o_ready = (state == IDLE).
REQ-015 In IDLE with enqueue only and !o_full: node[size] <= i_data, size+1, then go to SORT.
REQ-016 In IDLE with dequeue only and !o_empty: node[0] <= node[size-1], node[size-1] <= 0, size-1, then go to SORT.
REQ-017 In IDLE with both requests and !o_empty: node[0] <= i_data, size unchanged, then go to SORT.
REQ-018 In IDLE with both requests and o_empty: the block SHALL treat the cycle as enqueue only.
REQ-019 Enqueue while full (without dequeue) and dequeue while empty SHALL be ignored: no state change, and the FSM stays in IDLE.
REQ-020 Requests while o_ready is low SHALL be ignored and not queued.
REQ-021 SORT SHALL last exactly 2*TREE_DEPTH cycles, counted by a phase counter, then return to IDLE.
REQ-022 In SORT cycle k, only comparators whose parent level has the same parity as k SHALL update node registers; the other levels hold.
REQ-023 A comparator update SHALL swap the parent with its larger child when that child is strictly greater (ties go to the right child); otherwise it leaves the nodes unchanged.
REQ-024 On every return to IDLE, the max-heap property SHALL hold and o_data SHALL equal the maximum occupied key.
REQ-025 o_data SHALL be driven directly from node[0]; it is 0 when empty.
REQ-026 Operation latency SHALL be accept edge + 2*TREE_DEPTH cycles before o_ready returns high.

Reset
REQ-027 i_rst high at a clock edge SHALL clear all nodes to 0, set size to 0 and the phase counter to 0, and force state to IDLE, including when asserted mid-SORT.
REQ-028 The post-reset outputs SHALL be o_data=0, o_ready=1, o_empty=1, o_full=0, o_size=0.

Configuration
REQ-029 With REGISTER_TREE_ERR_EN defined, the block SHALL add output ports o_overflow and o_underflow, each of width 1.
REQ-030 These flags SHALL be sticky: set by an ignored enqueue-while-full or dequeue-while-empty in IDLE, and cleared only by i_rst.
REQ-031 Without REGISTER_TREE_ERR_EN, these ports and their logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-032 Package register_tree_pkg SHALL hold the state enum (IDLE, SORT) and helper functions for node count and parent/child index.
REQ-033 Module comparator SHALL be instantiated once per internal node as the swap datapath; the register_tree module owns all registers and the phase gating.

Verification
REQ-034 Scenario: reset, then enqueue 5, 9, 3, 7, each after o_ready -> o_data=9, o_size=4, o_empty=0.
REQ-035 Scenario: from the REQ-034 state, dequeue four times -> o_data sequence before each dequeue is 9, 7, 5, 3; the final state has o_empty=1, o_data=0.
REQ-036 Scenario: TREE_DEPTH=3, enqueue 1..7 -> o_full=1, o_data=7; an 8th enqueue of 100 is ignored, o_data stays 7, and o_overflow=1 (macro on).
REQ-037 Scenario: with size 3 holding {8, 4, 2}, simultaneous enqueue 6 + dequeue -> o_size=3, o_data=6; then the next dequeue gives 4 as the new root.
REQ-038 Scenario: enqueue 9 and assert i_rst on the 2nd SORT cycle -> next cycle o_ready=1, o_size=0, o_data=0.
REQ-039 Scenario: pulse enqueue 50 on every cycle during SORT -> exactly one insert occurs, o_ready is low for exactly 2*TREE_DEPTH cycles, and the dequeue-on-empty at start sets o_underflow=1.
